hp_mult_result_buffer: RTL and testbench

HP_MULT_RESULT_BUFFER -- requirements
Module: hp_mult_result_buffer

---
 rtl/hp_mult_result_buffer.sv | 189 ++++++++++++++++++
 tb/tb_hp_mult_result_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hp_mult_result_buffer.sv
// hp_mult_result_buffer
//   Result FIFO sitting behind a half-precision multiplier. Holds DEPTH
//   {product, exception} entries with a 1-cycle push-to-visible latency.
//   It also keeps sticky exception flags and, optionally, per-code
//   saturating event counters.
//
// Parameters
//   DEPTH        entry count; 2, 4, 8 or 16 (power of two, so pointers wrap freely)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake; in_ready depends only on registered level
//   in_product, in_exc      multiplier result and exception code (00/01 uf/10 of/11 nan)
//   out_valid / out_ready   downstream handshake for the head entry
//   out_product, out_exc    head entry, read combinationally from storage
//   out_zero                head product is +/-0
//   level                   current occupancy
//   sticky_exc              sticky flags [0] uf, [1] of, [2] nan
//   clear_sticky            synchronous clear of sticky flags (and counters)
//   cnt_uf, cnt_of, cnt_nan saturating 8-bit counters, present only when
//                           HP_RESBUF_EXC_CNT_EN is defined
module hp_mult_result_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_product,
  input  logic [1:0]                in_exc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_product,
  output logic [1:0]                out_exc,
  output logic                      out_zero,
  input  logic                      clear_sticky,
`ifdef HP_RESBUF_EXC_CNT_EN
  output logic [7:0]                cnt_uf,
  output logic [7:0]                cnt_of,
  output logic [7:0]                cnt_nan,
`endif
  output logic [$clog2(DEPTH):0]    level,
  output logic [2:0]                sticky_exc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]  exc;
    logic [15:0] product;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [2:0]         sticky_q, sticky_d;

  logic               push_c;
  logic               pop_c;
  entry_t             head_c;

  // Handshake status comes only from the registered level.
  assign in_ready  = (level_q < LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Head entry presented straight from storage.
  assign head_c      = mem_q[rd_ptr_q];
  assign out_product = head_c.product;
  assign out_exc     = head_c.exc;
  assign out_zero    = (head_c.product[14:0] == 15'd0);

  assign level      = level_q;
  assign sticky_exc = sticky_q;

  // Storage write.
  always_comb begin
    mem_d = mem_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = entry_t'{exc: in_exc, product: in_product};
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so the
  // natural pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Sticky flags: clear first, then a push's flag overrides for its bit.
  always_comb begin
    sticky_d = clear_sticky ? 3'b000 : sticky_q;
    if (push_c) begin
      case (in_exc)
        2'b01:   sticky_d[0] = 1'b1;
        2'b10:   sticky_d[1] = 1'b1;
        2'b11:   sticky_d[2] = 1'b1;
        default: sticky_d    = sticky_d;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef HP_RESBUF_EXC_CNT_EN
  logic [7:0] cnt_uf_q, cnt_uf_d;
  logic [7:0] cnt_of_q, cnt_of_d;
  logic [7:0] cnt_nan_q, cnt_nan_d;
  logic       hit_uf_c, hit_of_c, hit_nan_c;

  assign hit_uf_c  = push_c && (in_exc == 2'b01);
  assign hit_of_c  = push_c && (in_exc == 2'b10);
  assign hit_nan_c = push_c && (in_exc == 2'b11);

  assign cnt_uf  = cnt_uf_q;
  assign cnt_of  = cnt_of_q;
  assign cnt_nan = cnt_nan_q;

  // Saturating counters; an increment in the same cycle as a clear
  // keeps counting from the current value.
  always_comb begin
    cnt_uf_d  = cnt_uf_q;
    cnt_of_d  = cnt_of_q;
    cnt_nan_d = cnt_nan_q;
    if (hit_uf_c) begin
      cnt_uf_d = (cnt_uf_q == 8'hFF) ? cnt_uf_q : cnt_uf_q + 8'd1;
    end else if (clear_sticky) begin
      cnt_uf_d = 8'd0;
    end
    if (hit_of_c) begin
      cnt_of_d = (cnt_of_q == 8'hFF) ? cnt_of_q : cnt_of_q + 8'd1;
    end else if (clear_sticky) begin
      cnt_of_d = 8'd0;
    end
    if (hit_nan_c) begin
      cnt_nan_d = (cnt_nan_q == 8'hFF) ? cnt_nan_q : cnt_nan_q + 8'd1;
    end else if (clear_sticky) begin
      cnt_nan_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_uf_q  <= '0;
      cnt_of_q  <= '0;
      cnt_nan_q <= '0;
    end else begin
      cnt_uf_q  <= cnt_uf_d;
      cnt_of_q  <= cnt_of_d;
      cnt_nan_q <= cnt_nan_d;
    end
  end
`endif

endmodule

// File: tb/tb_hp_mult_result_buffer.sv
// Bench for hp_mult_result_buffer: queue-based reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_hp_mult_result_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_product;
  logic [1:0]  in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [1:0]  out_exc;
  logic        out_zero;
  logic        clear_sticky;
  logic [2:0]  level;
  logic [2:0]  sticky_exc;
`ifdef HP_RESBUF_EXC_CNT_EN
  logic [7:0]  cnt_uf, cnt_of, cnt_nan;
  int          m_uf, m_of, m_nan;
`endif

  hp_mult_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_exc(out_exc), .out_zero(out_zero),
    .clear_sticky(clear_sticky),
`ifdef HP_RESBUF_EXC_CNT_EN
    .cnt_uf(cnt_uf), .cnt_of(cnt_of), .cnt_nan(cnt_nan),
`endif
    .level(level), .sticky_exc(sticky_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  logic [17:0] mq[$];          // {exc, product}
  logic [2:0]  m_sticky = 3'b000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("m_sticky", 32'(sticky_exc), 32'(m_sticky));
      if (mq.size() != 0) begin
        chk("m_out_product", 32'(out_product), 32'(mq[0][15:0]));
        chk("m_out_exc", 32'(out_exc), 32'(mq[0][17:16]));
        chk("m_out_zero", 32'(out_zero), 32'(mq[0][14:0] == 15'd0));
      end
`ifdef HP_RESBUF_EXC_CNT_EN
      chk("m_cnt_uf", 32'(cnt_uf), 32'(m_uf));
      chk("m_cnt_of", 32'(cnt_of), 32'(m_of));
      chk("m_cnt_nan", 32'(cnt_nan), 32'(m_nan));
`endif
    end
  end

  // One clock of stimulus, starting and ending on a falling edge.
  task automatic step(input logic iv, input logic [15:0] p, input logic [1:0] e,
                      input logic ordy, input logic clr);
    bit push, pop;
    in_valid = iv; in_product = p; in_exc = e; out_ready = ordy; clear_sticky = clr;
    push = iv && (mq.size() < DEPTH);
    pop  = ordy && (mq.size() != 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (clr) m_sticky = 3'b000;
`ifdef HP_RESBUF_EXC_CNT_EN
    if (push && e == 2'b01) m_uf  = (m_uf  < 255) ? m_uf  + 1 : 255; else if (clr) m_uf  = 0;
    if (push && e == 2'b10) m_of  = (m_of  < 255) ? m_of  + 1 : 255; else if (clr) m_of  = 0;
    if (push && e == 2'b11) m_nan = (m_nan < 255) ? m_nan + 1 : 255; else if (clr) m_nan = 0;
`endif
    if (push) begin
      mq.push_back({e, p});
      if (e != 2'b00) m_sticky[e - 2'd1] = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input logic [15:0] exp);
    chk(nm, 32'(out_product), 32'(exp));
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_exc = '0;
    out_ready = 1'b0; clear_sticky = 1'b0;
`ifdef HP_RESBUF_EXC_CNT_EN
    m_uf = 0; m_of = 0; m_nan = 0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_sticky", 32'(sticky_exc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single transfer: 2.5 x 4 = 10.0
    step(1'b1, 16'h4900, 2'b00, 1'b0, 1'b0);
    chk("seq_valid", 32'(out_valid), 32'd1);
    chk("seq_product", 32'(out_product), 32'h4900);
    chk("seq_zero", 32'(out_zero), 32'd0);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("seq_level", 32'(level), 32'd0);

    // Pop while empty is ignored.
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    chk("empty_pop_level", 32'(level), 32'd0);

    // Fill past full, drain, then wrap.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 16'(i), 2'b00, 1'b0, 1'b0);
      if (i == 4) chk("full_in_ready", 32'(in_ready), 32'd0);
    end
    chk("full_level", 32'(level), 32'd4);
    for (int i = 1; i <= 4; i++) pop_expect("drain1", 16'(i));
    chk("drain1_empty", 32'(out_valid), 32'd0);
    step(1'b1, 16'h0005, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h0006, 2'b00, 1'b0, 1'b0);
    pop_expect("wrap", 16'h0005);
    pop_expect("wrap", 16'h0006);

    // Full with pop in the same cycle: push ignored, slot free next cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h1000 + 16'(i), 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 2'b00, 1'b1, 1'b0);
    chk("full_pop_level", 32'(level), 32'd3);
    step(1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0);
    chk("refill_level", 32'(level), 32'd4);
    for (int i = 1; i < 4; i++) pop_expect("full_pop_order", 16'h1000 + 16'(i));
    pop_expect("refill_tail", 16'hBEEF);

    // Simultaneous push/pop at level 2.
    step(1'b1, 16'h3800, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h4000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("simul_head", 32'(out_product), (i == 0) ? 32'h3800 : (i == 1) ? 32'h4000 : 32'h3C00);
      step(1'b1, 16'h3C00, 2'b00, 1'b1, 1'b0);
      chk("simul_level", 32'(level), 32'd2);
    end
    pop_expect("simul_drain", 16'h3C00);
    pop_expect("simul_drain", 16'h3C00);

    // Exceptions and sticky flags.
    step(1'b1, 16'h0000, 2'b01, 1'b0, 1'b0);
    step(1'b1, 16'h7C00, 2'b10, 1'b0, 1'b0);
    step(1'b1, 16'h7D04, 2'b11, 1'b0, 1'b0);
    chk("exc_sticky", 32'(sticky_exc), 32'h7);
    chk("exc_zero", 32'(out_zero), 32'd1);
    step(1'b1, 16'h8000, 2'b01, 1'b1, 1'b1);
    chk("clr_push_sticky", 32'(sticky_exc), 32'h1);
    step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1);
    chk("clr_sticky", 32'(sticky_exc), 32'h0);
    pop_expect("exc_of", 16'h7C00);
    pop_expect("exc_nan", 16'h7D04);
    chk("neg_zero", 32'(out_zero), 32'd1);
    pop_expect("neg_zero_prod", 16'h8000);

    // Reset mid-stream at level 3.
    step(1'b1, 16'h1111, 2'b01, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 2'b10, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 2'b00, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_sticky", 32'(sticky_exc), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    mq.delete();
    m_sticky = 3'b000;
`ifdef HP_RESBUF_EXC_CNT_EN
    m_uf = 0; m_of = 0; m_nan = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(1'b1, 16'h4444, 2'b00, 1'b0, 1'b0);
    chk("post_rst_push", 32'(out_product), 32'h4444);
    chk("post_rst_level", 32'(level), 32'd1);
    pop_expect("post_rst_pop", 16'h4444);

`ifdef HP_RESBUF_EXC_CNT_EN
    for (int i = 0; i < 300; i++) step(1'b1, 16'h7C00, 2'b10, 1'b1, 1'b0);
    chk("cnt_of_sat", 32'(cnt_of), 32'd255);
    chk("cnt_uf_zero", 32'(cnt_uf), 32'd0);
    chk("cnt_nan_zero", 32'(cnt_nan), 32'd0);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b1);
    chk("cnt_clear", 32'(cnt_of), 32'd0);
`endif

    repeat (2) step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
